// File: rtl/fsmd_input_conditioner.sv
// rtl/fsmd_input_conditioner.sv - synchronise, debounce and init-pulse generation for FSMD inputs
//
// fsmd_input_conditioner_db: one synchroniser chain plus whole-code debouncer.
//   clk, rst_n        clock, synchronous active-low reset
//   raw[W]            asynchronous raw field
//   val[W]            committed (debounced) value, registered
//   commit            high in the cycle whose edge commits a new value
//   abandon           high in the cycle whose edge drops an in-progress attempt
//
// fsmd_input_conditioner: top level.
//   clk, rst_n        clock, synchronous active-low reset
//   p_raw[2], s_raw[2], start_raw   asynchronous field inputs
//   p[2], s[2]        debounced codes to the FSMD
//   i                 init pulse to the FSMD
//   upd               one-cycle strobe when p and/or s changes
//   glitch_cnt[8]     saturating count of rejected candidate changes

module fsmd_input_conditioner_db #(
    parameter int W           = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] raw,
    output logic [W-1:0] val,
    output logic         commit,
    output logic         abandon
);

    logic [W-1:0]     sync_q [SYNC_STAGES];
    logic [W-1:0]     sample;
    logic [W-1:0]     cand;
    logic [CNT_W-1:0] cnt;
    logic             hit;
    logic             same;
    logic             full;

    assign sample = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    always_comb begin
        hit     = (sample == val);
        same    = (sample == cand);
        full    = (cnt == CNT_W'(DEBOUNCE - 1));
        // Commit happens on the edge after the counter has already reached DEBOUNCE-1,
        // so the new value needs DEBOUNCE consecutive matching samples.
        commit  = !hit && same && full;
        abandon = (cnt != '0) && (hit || !same);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val  <= '0;
            cand <= '0;
            cnt  <= '0;
        end else if (hit) begin
            cnt <= '0;
        end else if (same) begin
            if (full) begin
                val <= cand;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cand <= sample;
            cnt  <= CNT_W'(1);
        end
    end

endmodule

module fsmd_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 3,
    parameter int INIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] p_raw,
    input  logic [1:0] s_raw,
    input  logic       start_raw,
    output logic [1:0] p,
    output logic [1:0] s,
    output logic       i,
    output logic       upd,
    output logic [7:0] glitch_cnt
);

    localparam int IW = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_PULSE
    } state_t;

    state_t        state, state_d;
    logic [IW-1:0] icnt, icnt_d;
    logic          i_d;

    logic p_commit, p_abandon;
    logic s_commit, s_abandon;
    logic start_val, start_commit, start_abandon;
    logic start_rise;

    fsmd_input_conditioner_db #(.W(2), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_p (
        .clk(clk), .rst_n(rst_n), .raw(p_raw), .val(p), .commit(p_commit), .abandon(p_abandon)
    );

    fsmd_input_conditioner_db #(.W(2), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_s (
        .clk(clk), .rst_n(rst_n), .raw(s_raw), .val(s), .commit(s_commit), .abandon(s_abandon)
    );

    fsmd_input_conditioner_db #(.W(1), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_start (
        .clk(clk), .rst_n(rst_n), .raw(start_raw), .val(start_val), .commit(start_commit),
        .abandon(start_abandon)
    );

    // A 1-bit commit always flips the value, so committing while low is a rising edge.
    assign start_rise = start_commit && !start_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd        <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            upd <= p_commit || s_commit;
            if ((p_abandon || s_abandon || start_abandon) && (glitch_cnt != 8'hFF))
                glitch_cnt <= glitch_cnt + 8'd1;
        end
    end

    // INIT starts with icnt=0 so i rises on the first post-reset edge; PULSE is entered
    // with icnt=1 because i is already raised on the entry edge.
    always_comb begin
        state_d = state;
        icnt_d  = icnt;
        i_d     = 1'b0;
        case (state)
            ST_INIT, ST_PULSE: begin
                if (icnt == IW'(INIT_CYCLES)) begin
                    state_d = ST_RUN;
                    icnt_d  = '0;
                end else begin
                    icnt_d = icnt + IW'(1);
                    i_d    = 1'b1;
                end
            end
            ST_RUN: begin
                if (start_rise) begin
                    state_d = ST_PULSE;
                    icnt_d  = IW'(1);
                    i_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                icnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
            icnt  <= '0;
            i     <= 1'b0;
        end else begin
            state <= state_d;
            icnt  <= icnt_d;
            i     <= i_d;
        end
    end

endmodule

// File: tb/tb_fsmd_input_conditioner.sv
// tb/tb_fsmd_input_conditioner.sv - scoreboard bench for fsmd_input_conditioner
module tb_fsmd_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] p_raw, s_raw;
    logic       start_raw;
    logic [1:0] p, s;
    logic       i, upd;
    logic [7:0] glitch_cnt;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         kind;   // 0: upd event, 1: i event
        int         cyc;
        logic [1:0] p;
        logic [1:0] s;
    } ev_t;

    ev_t exp_q[$];

    fsmd_input_conditioner dut (
        .clk(clk), .rst_n(rst_n), .p_raw(p_raw), .s_raw(s_raw), .start_raw(start_raw),
        .p(p), .s(s), .i(i), .upd(upd), .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_upd(input int c, input logic [1:0] ep, input logic [1:0] es);
        ev_t e;
        e.kind = 0; e.cyc = c; e.p = ep; e.s = es;
        exp_q.push_back(e);
    endtask

    task automatic push_i(input int c);
        ev_t e;
        e.kind = 1; e.cyc = c; e.p = 2'b00; e.s = 2'b00;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle where the DUT presents upd or i is matched against the queue.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (upd) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL upd_unexpected: cycle %0d p=%b s=%b, none expected", cyc, p, s);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != 0 || e.cyc != cyc || e.p !== p || e.s !== s) begin
                        errors++;
                        $display("FAIL upd_event: got cycle %0d p=%b s=%b, expected kind %0d cycle %0d p=%b s=%b",
                                 cyc, p, s, e.kind, e.cyc, e.p, e.s);
                    end
                end
            end
            if (i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL i_unexpected: cycle %0d, none expected", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != 1 || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL i_event: got cycle %0d, expected kind %0d cycle %0d",
                                 cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; p_raw = 2'b00; s_raw = 2'b00; start_raw = 1'b0;

        // Reset state
        tick(3);
        chk("reset_p", p, 0);
        chk("reset_s", s, 0);
        chk("reset_i", i, 0);
        chk("reset_upd", upd, 0);
        chk("reset_glitch", glitch_cnt, 0);
        push_i(cyc + 1);
        rst_n = 1'b1;
        tick(4);

        // p 00->01 held: commit after 6 edges
        p_raw = 2'b01;
        push_upd(cyc + 6, 2'b01, 2'b00);
        tick(10);
        chk("p_commit_glitch", glitch_cnt, 0);
        chk("p_commit_s", s, 0);

        // s glitch of 2 cycles is rejected
        s_raw = 2'b11;
        tick(2);
        s_raw = 2'b00;
        tick(8);
        chk("s_glitch_once", glitch_cnt, 1);
        chk("s_glitch_hold", s, 0);
        for (int k = 0; k < 299; k++) begin
            s_raw = 2'b11;
            tick(2);
            s_raw = 2'b00;
            tick(3);
        end
        tick(5);
        chk("glitch_saturate", glitch_cnt, 255);

        // Simultaneous p and s change: one upd pulse
        p_raw = 2'b10; s_raw = 2'b01;
        push_upd(cyc + 6, 2'b10, 2'b01);
        tick(10);
        for (int k = 0; k < 20; k++) begin
            s_raw = (k % 2 == 0) ? 2'b10 : 2'b01;
            tick(1);
        end
        tick(8);
        chk("s_toggle_hold", s, 1);
        chk("p_after_toggle", p, 2);

        // Start: short request ignored, long request gives one pulse, re-arm after low
        start_raw = 1'b1;
        tick(3);
        start_raw = 1'b0;
        tick(10);
        start_raw = 1'b1;
        push_i(cyc + 6);
        tick(10);
        start_raw = 1'b0;
        tick(6);
        start_raw = 1'b1;
        push_i(cyc + 6);
        tick(12);
        start_raw = 1'b0;
        tick(10);

        // Reset during cycle 3 of a p debounce
        p_raw = 2'b01;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        chk("mid_reset_p", p, 0);
        chk("mid_reset_s", s, 0);
        chk("mid_reset_i", i, 0);
        chk("mid_reset_glitch", glitch_cnt, 0);
        n = cyc;
        push_i(n + 1);
        push_upd(n + 6, 2'b01, 2'b01);
        rst_n = 1'b1;
        tick(10);

        // Reset during a PULSE
        start_raw = 1'b1;
        push_i(cyc + 6);
        tick(6);
        rst_n = 1'b0;
        tick(1);
        chk("pulse_reset_i", i, 0);
        chk("pulse_reset_p", p, 0);
        chk("pulse_reset_upd", upd, 0);
        n = cyc;
        push_i(n + 1);
        push_upd(n + 6, 2'b01, 2'b01);
        push_i(n + 6);
        rst_n = 1'b1;
        tick(8);
        start_raw = 1'b0;
        tick(10);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
